axis_test_pattern_checker: RTL and testbench

- AXI-Stream sink that checks the counting test pattern produced by the team's pattern generator and reports its integrity.
- Each lane j of a beat must carry {counter, j}. The counter is common to all lanes of a beat and increments by 1 per accepted beat.
- Sits at the far end of a loopback or data path under test (DMA, FIFO, CDC, serializer), with optional pseudo-random backpressure.
- Exposes lock status, an error pulse, and saturating error/beat counters to a CSR block.

---
 rtl/axis_pkg.sv | 24 ++
 rtl/axis_if.sv | 13 +
 rtl/lfsr16.sv | 26 ++
 rtl/axis_test_pattern_checker.sv | 150 +++++++++++++++
 tb/tb_axis_test_pattern_checker.sv | 322 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axis_pkg.sv
// Shared AXI-Stream configuration types plus the test-pattern checker constants.
// The LFSR taps are a mask on a right-shifting register: feedback = XOR of masked bits.
package axis_pkg;

    typedef struct packed {
        int unsigned N;
    } axis_cfg_t;

    localparam axis_cfg_t AXIS_CFG_DEFAULT = '{N: 16};

    localparam logic [15:0] tp_lfsr_seed = 16'hACE1;
    // x^16+x^14+x^13+x^11+1 in right-shift form taps bits 0, 2, 3 and 5
    localparam logic [15:0] tp_lfsr_taps = 16'h002D;

    typedef enum logic {
        TP_HUNT,
        TP_LOCKED
    } tp_state_t;

    function automatic logic [15:0] tp_lfsr_step(input logic [15:0] s, input logic [15:0] taps);
        return {^(s & taps), s[15:1]};
    endfunction

endpackage

// File: rtl/axis_if.sv
// AXI-Stream channel; only the handshake and data are carried here.
interface axis_if
    import axis_pkg::*;
#(
    parameter axis_cfg_t CONFIG = AXIS_CFG_DEFAULT
);
    logic                     tvalid;
    logic                     tready;
    logic [CONFIG.N*8-1:0]    tdata;

    modport master (output tvalid, output tdata, input tready);
    modport slave  (input tvalid, input tdata, output tready);
endinterface

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR with parameterised seed and tap mask; advances while enable is high.
module lfsr16
    import axis_pkg::*;
#(
    parameter logic [15:0] SEED = tp_lfsr_seed,
    parameter logic [15:0] TAPS = tp_lfsr_taps
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        enable,
    output logic [15:0] state
);

    logic [15:0] state_reg;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_reg <= SEED;
        end else if (enable) begin
            state_reg <= tp_lfsr_step(state_reg, TAPS);
        end
    end

    assign state = state_reg;

endmodule

// File: rtl/axis_test_pattern_checker.sv
// AXI-Stream sink verifying the counting pattern {counter, lane} on every lane of every beat,
// with optional LFSR backpressure and saturating error/beat counters.
module axis_test_pattern_checker
    import axis_pkg::*;
#(
    parameter axis_cfg_t CONFIG = AXIS_CFG_DEFAULT,
    parameter int        W      = 4,
    parameter int        WPB    = 4,
    parameter int        CNT_W  = 32
) (
    input  logic             aclk,
    input  logic             aresetn,
    axis_if.slave            axis_in,
    input  logic             enable,
    input  logic             clear,
    input  logic             stall_en,
    output logic             locked,
    output logic             error,
    output logic [CNT_W-1:0] error_count,
    output logic [CNT_W-1:0] beat_count
);

    localparam int N    = CONFIG.N;
    localparam int W_LG = $clog2(W);
    localparam int CW   = W * 8 - W_LG;

    generate
        if (W < 2) begin : g_bad_w
            $fatal(1, "axis_test_pattern_checker: W must be >= 2");
        end
        if ((WPB < 1) || ((WPB & (WPB - 1)) != 0)) begin : g_bad_wpb
            $fatal(1, "axis_test_pattern_checker: WPB must be a power of two");
        end
        if (N != W * WPB) begin : g_bad_n
            $fatal(1, "axis_test_pattern_checker: CONFIG.N must equal W*WPB");
        end
    endgenerate

    tp_state_t         state_reg, state_next;
    logic [CW-1:0]     expected_reg, expected_next;
    logic              tready_reg;
    logic [15:0]       lfsr_state;
    logic              unused_lfsr_bits;
    logic [WPB-1:0]    lane_ok;
    logic [CW-1:0]     lane0_cnt;
    logic              beat_ok;
    logic              accept;
    logic              beat_vld_reg;
    logic              mismatch_reg;
    logic              locked_reg;
    logic              error_reg;
    logic [CNT_W-1:0]  error_count_reg;
    logic [CNT_W-1:0]  beat_count_reg;

    lfsr16 #(
        .SEED (tp_lfsr_seed),
        .TAPS (tp_lfsr_taps)
    ) u_lfsr (
        .aclk    (aclk),
        .aresetn (aresetn),
        .enable  (1'b1),
        .state   (lfsr_state)
    );

    // Only bit 0 throttles tready; the rest of the state is internal to the sequence.
    assign unused_lfsr_bits = ^lfsr_state[15:1];

    generate
        for (genvar gi = 0; gi < WPB; gi++) begin : g_lane
            logic [W*8-1:0] word;
            assign word        = axis_in.tdata[gi*W*8 +: W*8];
            assign lane_ok[gi] = (word[W*8-1:W_LG] == expected_reg) &&
                                 (word[W_LG-1:0] == W_LG'(gi));
        end
    endgenerate

    assign lane0_cnt = axis_in.tdata[W*8-1:W_LG];
    assign beat_ok   = &lane_ok;

    // A beat presented together with clear, or while disabled, is dropped.
    assign accept = axis_in.tvalid & tready_reg & enable & ~clear;

    always_comb begin
        state_next    = state_reg;
        expected_next = expected_reg;
        if (clear || !enable) begin
            state_next = TP_HUNT;
        end else if (accept) begin
            state_next = TP_LOCKED;
            if ((state_reg == TP_LOCKED) && beat_ok) begin
                expected_next = expected_reg + CW'(1);
            end else begin
                expected_next = lane0_cnt + CW'(1);
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_reg    <= TP_HUNT;
            expected_reg <= '0;
            tready_reg   <= 1'b0;
        end else begin
            state_reg    <= state_next;
            expected_reg <= expected_next;
            tready_reg   <= enable & (~stall_en | lfsr_state[0]);
        end
    end

    // Compare result is registered, then folded into the outputs one edge later.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            beat_vld_reg    <= 1'b0;
            mismatch_reg    <= 1'b0;
            locked_reg      <= 1'b0;
            error_reg       <= 1'b0;
            error_count_reg <= '0;
            beat_count_reg  <= '0;
        end else if (clear) begin
            beat_vld_reg    <= 1'b0;
            mismatch_reg    <= 1'b0;
            locked_reg      <= 1'b0;
            error_reg       <= 1'b0;
            error_count_reg <= '0;
            beat_count_reg  <= '0;
        end else begin
            beat_vld_reg <= accept;
            mismatch_reg <= accept & (state_reg == TP_LOCKED) & ~beat_ok;
            error_reg    <= beat_vld_reg & mismatch_reg;
            if (!enable) begin
                locked_reg <= 1'b0;
            end else if (beat_vld_reg) begin
                locked_reg <= 1'b1;
            end
            if (beat_vld_reg && (beat_count_reg != '1)) begin
                beat_count_reg <= beat_count_reg + CNT_W'(1);
            end
            if (beat_vld_reg && mismatch_reg && (error_count_reg != '1)) begin
                error_count_reg <= error_count_reg + CNT_W'(1);
            end
        end
    end

    assign axis_in.tready = tready_reg;
    assign locked         = locked_reg;
    assign error          = error_reg;
    assign error_count    = error_count_reg;
    assign beat_count     = beat_count_reg;

endmodule

// File: tb/tb_axis_test_pattern_checker.sv
// Directed-plus-random bench for axis_test_pattern_checker against a beat-level reference model.
module tb_axis_test_pattern_checker;
    import axis_pkg::*;

    localparam axis_cfg_t CFG = '{N: 16};
    localparam int W     = 4;
    localparam int WPB   = 4;
    localparam int CNT_W = 10;
    localparam int CW    = 30;
    localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

    logic aclk = 1'b0;
    logic aresetn = 1'b1;
    logic enable = 1'b0;
    logic clear = 1'b0;
    logic stall_en = 1'b0;
    logic locked, error;
    logic [CNT_W-1:0] error_count, beat_count;

    axis_if #(.CONFIG(CFG)) axis ();

    axis_test_pattern_checker #(
        .CONFIG (CFG),
        .W      (W),
        .WPB    (WPB),
        .CNT_W  (CNT_W)
    ) dut (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .axis_in     (axis),
        .enable      (enable),
        .clear       (clear),
        .stall_en    (stall_en),
        .locked      (locked),
        .error       (error),
        .error_count (error_count),
        .beat_count  (beat_count)
    );

    always #5 aclk = ~aclk;

    int checks = 0;
    int errors = 0;
    int hs_count = 0;

    // Reference model: m_* is the checker's internal view, v_* what the outputs show.
    logic [15:0]       lfsr_m;
    logic              v_tready;
    logic              m_locked, m_pulse, v_locked, v_error;
    logic [CW-1:0]     m_exp;
    int unsigned       m_beats, m_errs, v_beats, v_errs;

    always @(posedge aclk or negedge aresetn) begin : model
        logic [31:0] word;
        logic [CW-1:0] c0;
        bit ok;
        if (!aresetn) begin
            lfsr_m   <= 16'hACE1;
            v_tready <= 1'b0;
            m_locked <= 1'b0; m_pulse <= 1'b0; m_exp <= '0;
            m_beats  <= 0;    m_errs  <= 0;
            v_locked <= 1'b0; v_error <= 1'b0; v_beats <= 0; v_errs <= 0;
        end else begin
            lfsr_m   <= {lfsr_m[0] ^ lfsr_m[2] ^ lfsr_m[3] ^ lfsr_m[5], lfsr_m[15:1]};
            v_tready <= enable & (~stall_en | lfsr_m[0]);
            if (clear) begin
                m_locked <= 1'b0; m_pulse <= 1'b0; m_beats <= 0; m_errs <= 0;
                v_locked <= 1'b0; v_error <= 1'b0; v_beats <= 0; v_errs <= 0;
            end else begin
                v_beats  <= m_beats;
                v_errs   <= m_errs;
                v_error  <= m_pulse;
                v_locked <= enable ? m_locked : 1'b0;
                m_pulse  <= 1'b0;
                if (!enable) begin
                    m_locked <= 1'b0;
                end else if (axis.tvalid && axis.tready) begin
                    c0 = axis.tdata[31:2];
                    if (!m_locked) begin
                        m_locked <= 1'b1;
                        m_exp    <= c0 + 1;
                    end else begin
                        ok = 1;
                        for (int j = 0; j < WPB; j++) begin
                            word = axis.tdata[j*32 +: 32];
                            if (word[31:2] != m_exp || int'(word[1:0]) != j) ok = 0;
                        end
                        if (ok) begin
                            m_exp <= m_exp + 1;
                        end else begin
                            m_exp   <= c0 + 1;
                            m_pulse <= 1'b1;
                            if (m_errs != CNT_MAX) m_errs <= m_errs + 1;
                        end
                    end
                    if (m_beats != CNT_MAX) m_beats <= m_beats + 1;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_cycle();
        check("tready", 64'(axis.tready), 64'(v_tready));
        check("locked", 64'(locked), 64'(v_locked));
        check("error", 64'(error), 64'(v_error));
        check("error_count", 64'(error_count), 64'(v_errs));
        check("beat_count", 64'(beat_count), 64'(v_beats));
    endtask

    task automatic cyc();
        @(negedge aclk);
        check_cycle();
        @(posedge aclk);
        #1;
    endtask

    task automatic idle(input int n);
        axis.tvalid = 1'b0;
        repeat (n) cyc();
    endtask

    function automatic logic [127:0] make_beat(input logic [CW-1:0] cnt, input int bad_lane,
                                               input logic [1:0] bad_idx);
        logic [127:0] d;
        for (int j = 0; j < WPB; j++) d[j*32 +: 32] = {cnt, 2'(j)};
        if (bad_lane >= 0) d[bad_lane*32 +: 2] = bad_idx;
        return d;
    endfunction

    // Presents one beat and returns just after the edge that accepted it.
    task automatic send_beat(input logic [CW-1:0] cnt, input int bad_lane, input logic [1:0] bad_idx);
        int n;
        axis.tvalid = 1'b1;
        axis.tdata  = make_beat(cnt, bad_lane, bad_idx);
        n = 0;
        forever begin
            @(negedge aclk);
            check_cycle();
            if (axis.tready) break;
            n++;
            if (n > 200) begin
                check("handshake_timeout", 64'(n), 64'(0));
                break;
            end
            @(posedge aclk);
            #1;
        end
        @(posedge aclk);
        #1;
        hs_count++;
    endtask

    task automatic do_clear();
        axis.tvalid = 1'b0;
        clear = 1'b1;
        @(posedge aclk);
        #1;
        clear = 1'b0;
        @(negedge aclk);
        check("clear_beats", 64'(beat_count), 64'(0));
        check("clear_errs", 64'(error_count), 64'(0));
        check("clear_locked", 64'(locked), 64'(0));
        @(posedge aclk);
        #1;
    endtask

    initial begin
        logic [CW-1:0] base;
        axis.tvalid = 1'b0;
        axis.tdata  = '0;

        #1 aresetn = 1'b0;
        #2;
        check("rst_tready", 64'(axis.tready), 64'(0));
        check("rst_locked", 64'(locked), 64'(0));
        check("rst_counts", 64'({error_count, beat_count}), 64'(0));
        @(negedge aclk);
        aresetn = 1'b1;
        enable  = 1'b1;
        idle(2);

        // 1000 clean beats from counter 0
        for (int i = 0; i < 1000; i++) send_beat(CW'(i), -1, 2'd0);
        idle(2);
        @(negedge aclk);
        check("t1_beats", 64'(beat_count), 64'(1000));
        check("t1_errs", 64'(error_count), 64'(0));
        check("t1_locked", 64'(locked), 64'(1));
        @(posedge aclk); #1;

        // dropping enable returns to HUNT and holds tready low
        enable = 1'b0;
        idle(3);
        enable = 1'b1;
        idle(2);

        // clear presented with an accepted beat: clear wins
        axis.tvalid = 1'b1;
        axis.tdata  = make_beat(CW'(7), -1, 2'd0);
        clear = 1'b1;
        @(negedge aclk);
        check("clr_acc_tready", 64'(axis.tready), 64'(1));
        @(posedge aclk); #1;
        clear = 1'b0;
        idle(2);
        @(negedge aclk);
        check("clr_acc_beats", 64'(beat_count), 64'(0));
        check("clr_acc_locked", 64'(locked), 64'(0));
        @(posedge aclk); #1;

        // pre-advanced generator
        do_clear();
        for (int i = 0; i < 10; i++) send_beat(CW'(32'h0123_4567 + i), -1, 2'd0);
        idle(2);
        @(negedge aclk);
        check("t2_errs", 64'(error_count), 64'(0));
        check("t2_locked", 64'(locked), 64'(1));
        @(posedge aclk); #1;

        // beat 50 with lane 2 index corrupted
        do_clear();
        for (int i = 1; i <= 100; i++) send_beat(CW'(i), (i == 50) ? 2 : -1, 2'd3);
        idle(2);
        @(negedge aclk);
        check("t3_errs", 64'(error_count), 64'(1));
        check("t3_beats", 64'(beat_count), 64'(100));
        @(posedge aclk); #1;

        // one dropped beat (99 -> 101)
        do_clear();
        for (int i = 0; i <= 150; i++) if (i != 100) send_beat(CW'(i), -1, 2'd0);
        idle(2);
        @(negedge aclk);
        check("t4_errs", 64'(error_count), 64'(1));
        @(posedge aclk); #1;

        // wrap through zero
        do_clear();
        for (int i = 0; i < 4; i++) send_beat(CW'((1 << 30) - 2 + i), -1, 2'd0);
        idle(2);
        @(negedge aclk);
        check("t5_errs", 64'(error_count), 64'(0));
        check("t5_beats", 64'(beat_count), 64'(4));
        @(posedge aclk); #1;

        // random gaps, corruptions and skips
        do_clear();
        base = CW'($urandom);
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
            if ($urandom_range(0, 31) == 0) base = base + CW'($urandom_range(2, 9));
            if ($urandom_range(0, 15) == 0)
                send_beat(base, int'($urandom_range(0, 3)), 2'($urandom));
            else
                send_beat(base, -1, 2'd0);
            base = base + 1;
        end
        idle(2);

        // saturation: repeated counter mismatches every beat after the first
        do_clear();
        for (int i = 0; i < 1030; i++) send_beat(CW'(5), -1, 2'd0);
        idle(2);
        @(negedge aclk);
        check("sat_beats", 64'(beat_count), 64'(CNT_MAX));
        check("sat_errs", 64'(error_count), 64'(CNT_MAX));
        @(posedge aclk); #1;
        send_beat(CW'(5), -1, 2'd0);
        axis.tvalid = 1'b0;
        @(posedge aclk); #1;
        @(negedge aclk);
        check("sat_err_pulse", 64'(error), 64'(1));
        check("sat_errs_hold", 64'(error_count), 64'(CNT_MAX));
        @(posedge aclk); #1;

        // LFSR backpressure with continuous tvalid
        do_clear();
        stall_en = 1'b1;
        hs_count = 0;
        base = CW'($urandom);
        for (int i = 0; i < 300; i++) send_beat(base + CW'(i), -1, 2'd0);
        @(negedge aclk);
        check_cycle();
        @(posedge aclk); #1;
        @(negedge aclk);
        check("stall_beats_hs", 64'(beat_count), 64'(hs_count));
        check("stall_errs", 64'(error_count), 64'(0));

        // asynchronous reset mid-stream
        @(posedge aclk);
        #3 aresetn = 1'b0;
        #1;
        check("arst_tready", 64'(axis.tready), 64'(0));
        check("arst_locked", 64'(locked), 64'(0));
        check("arst_errs", 64'(error_count), 64'(0));
        check("arst_beats", 64'(beat_count), 64'(0));
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        aresetn  = 1'b1;
        stall_en = 1'b0;
        @(posedge aclk); #1;
        base = CW'($urandom);
        for (int i = 0; i < 20; i++) send_beat(base + CW'(i), -1, 2'd0);
        idle(2);
        @(negedge aclk);
        check("relock_locked", 64'(locked), 64'(1));
        check("relock_errs", 64'(error_count), 64'(0));
        check("relock_beats", 64'(beat_count), 64'(20));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
